// File: rtl/cnn_pkg.sv
// Shared CNN definitions: streamer FSM states, default feature-map geometry
// common with conv_layer, and small sizing helpers.
package cnn_pkg;

  localparam int unsigned IMGROW      = 7;
  localparam int unsigned IMGCOL      = 7;
  localparam int unsigned KERNEL_SIZE = 3;
  localparam int unsigned CONV_WIDTH  = 20;
  localparam int unsigned PIX_WIDTH   = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2
  } state_t;

  // Valid-convolution output dimension.
  function automatic int unsigned out_dim(input int unsigned img, input int unsigned k);
    return img - k + 1;
  endfunction

  // Index width for a dimension; a dimension of 1 still needs a 1-bit index.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sat_clamp.sv
// Saturating requantizer: signed IN_WIDTH value -> unsigned TX_WIDTH pixel.
// Negative values go to 0, values above the pixel range go to all-ones.
//   x   : signed input element
//   y_c : clamped pixel (combinational)
module sat_clamp #(
  parameter int unsigned IN_WIDTH = 20,
  parameter int unsigned TX_WIDTH = 8
) (
  input  logic signed [IN_WIDTH-1:0] x,
  output logic        [TX_WIDTH-1:0] y_c
);

  localparam logic signed [IN_WIDTH-1:0] PIX_MAX =
    {{(IN_WIDTH-TX_WIDTH){1'b0}}, {TX_WIDTH{1'b1}}};

  always_comb begin
    y_c = x[TX_WIDTH-1:0];
    if (x[IN_WIDTH-1]) begin
      y_c = '0;
    end else if (x > PIX_MAX) begin
      y_c = '1;
    end
  end

endmodule

// File: rtl/conv_out_streamer.sv
// Captures one conv_layer feature map per frame handshake (clamped to
// pixels), then streams it row-major over a valid/ready interface.
//   clk, rst          : clock, asynchronous active-low reset
//   frame_valid/ready : frame capture handshake for conv_out
//   conv_out          : signed feature map presented in parallel
//   m_valid/m_ready   : pixel stream handshake
//   m_data            : clamped pixel
//   m_row, m_col      : coordinates of the current beat
//   m_last_col/m_last : end-of-row / end-of-frame markers
//   frame_cnt         : completed frames, wraps
module conv_out_streamer
  import cnn_pkg::*;
#(
  parameter int unsigned OUTROW    = out_dim(IMGROW, KERNEL_SIZE),
  parameter int unsigned OUTCOL    = out_dim(IMGCOL, KERNEL_SIZE),
  parameter int unsigned IN_WIDTH  = CONV_WIDTH,
  parameter int unsigned TX_WIDTH  = PIX_WIDTH,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        frame_valid,
  output logic                        frame_ready,
  input  logic signed [IN_WIDTH-1:0]  conv_out [0:OUTROW-1][0:OUTCOL-1],
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [TX_WIDTH-1:0]         m_data,
  output logic [idx_w(OUTROW)-1:0]    m_row,
  output logic [idx_w(OUTCOL)-1:0]    m_col,
  output logic                        m_last_col,
  output logic                        m_last,
  output logic [CNT_WIDTH-1:0]        frame_cnt
);

  localparam int unsigned RW = idx_w(OUTROW);
  localparam int unsigned CW = idx_w(OUTCOL);
  localparam logic [RW-1:0] LAST_ROW = RW'(OUTROW - 1);
  localparam logic [CW-1:0] LAST_COL = CW'(OUTCOL - 1);

  state_t              state_q, state_d;
  logic [TX_WIDTH-1:0] clamped_c [0:OUTROW-1][0:OUTCOL-1];
  logic [TX_WIDTH-1:0] pix_buf_q [0:OUTROW-1][0:OUTCOL-1];
  logic                capture_c;

  logic                 frame_ready_d, m_valid_d, m_last_col_d, m_last_d;
  logic [TX_WIDTH-1:0]  m_data_d;
  logic [RW-1:0]        m_row_d, nxt_row;
  logic [CW-1:0]        m_col_d, nxt_col;
  logic [CNT_WIDTH-1:0] frame_cnt_d;

  // Per-element clamp on the capture path.
  for (genvar r = 0; r < OUTROW; r++) begin : g_row
    for (genvar c = 0; c < OUTCOL; c++) begin : g_col
      sat_clamp #(
        .IN_WIDTH (IN_WIDTH),
        .TX_WIDTH (TX_WIDTH)
      ) u_clamp (
        .x   (conv_out[r][c]),
        .y_c (clamped_c[r][c])
      );
    end
  end

  // Next state and next registered outputs.
  always_comb begin
    state_d       = state_q;
    frame_ready_d = frame_ready;
    m_valid_d     = m_valid;
    m_data_d      = m_data;
    m_row_d       = m_row;
    m_col_d       = m_col;
    m_last_col_d  = m_last_col;
    m_last_d      = m_last;
    frame_cnt_d   = frame_cnt;
    capture_c     = 1'b0;
    nxt_row       = m_row;
    nxt_col       = m_col;

    // Row-major successor of the current beat.
    if (m_last_col) begin
      nxt_col = '0;
      nxt_row = m_row + RW'(1);
    end else begin
      nxt_col = m_col + CW'(1);
    end

    case (state_q)
      IDLE: begin
        frame_ready_d = 1'b1;
        if (frame_valid && frame_ready) begin
          capture_c     = 1'b1;
          frame_ready_d = 1'b0;
          state_d       = LOAD;
        end
      end
      LOAD: begin
        m_valid_d    = 1'b1;
        m_data_d     = pix_buf_q[0][0];
        m_row_d      = '0;
        m_col_d      = '0;
        m_last_col_d = (LAST_COL == '0);
        m_last_d     = (LAST_COL == '0) && (LAST_ROW == '0);
        state_d      = SEND;
      end
      SEND: begin
        if (m_valid && m_ready) begin
          if (m_last) begin
            m_valid_d     = 1'b0;
            frame_ready_d = 1'b1;
            frame_cnt_d   = frame_cnt + CNT_WIDTH'(1);
            state_d       = IDLE;
          end else begin
            m_data_d     = pix_buf_q[nxt_row][nxt_col];
            m_row_d      = nxt_row;
            m_col_d      = nxt_col;
            m_last_col_d = (nxt_col == LAST_COL);
            m_last_d     = (nxt_col == LAST_COL) && (nxt_row == LAST_ROW);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      frame_ready <= 1'b1;
      m_valid     <= 1'b0;
      m_data      <= '0;
      m_row       <= '0;
      m_col       <= '0;
      m_last_col  <= 1'b0;
      m_last      <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      state_q     <= state_d;
      frame_ready <= frame_ready_d;
      m_valid     <= m_valid_d;
      m_data      <= m_data_d;
      m_row       <= m_row_d;
      m_col       <= m_col_d;
      m_last_col  <= m_last_col_d;
      m_last      <= m_last_d;
      frame_cnt   <= frame_cnt_d;
    end
  end

  // Capture buffer: the only pixel source once a frame is accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < OUTROW; r++) begin
        for (int c = 0; c < OUTCOL; c++) begin
          pix_buf_q[r][c] <= '0;
        end
      end
    end else if (capture_c) begin
      pix_buf_q <= clamped_c;
    end
  end

endmodule

// File: tb/tb_conv_out_streamer.sv
// Directed bench for conv_out_streamer: reset, ramp, clamp, backpressure,
// mid-frame reset, back-to-back frames and frame counter wrap.
module tb_conv_out_streamer;

  localparam int R = 5;
  localparam int C = 5;
  localparam int N = R * C;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              frame_valid = 1'b0;
  logic              m_ready = 1'b0;
  logic signed [19:0] conv_out [0:R-1][0:C-1];

  logic        frame_ready, m_valid, m_last_col, m_last;
  logic [7:0]  m_data;
  logic [2:0]  m_row, m_col;
  logic [15:0] frame_cnt;

  logic        frame_ready2, m_valid2, m_last_col2, m_last2;
  logic [7:0]  m_data2;
  logic [2:0]  m_row2, m_col2;
  logic [1:0]  frame_cnt2;

  int checks = 0;
  int failures = 0;
  int cycle = 0;
  logic [7:0] exp_pix [0:N-1];

  conv_out_streamer #(
    .OUTROW(R), .OUTCOL(C), .IN_WIDTH(20), .TX_WIDTH(8), .CNT_WIDTH(16)
  ) dut (
    .clk(clk), .rst(rst), .frame_valid(frame_valid), .frame_ready(frame_ready),
    .conv_out(conv_out), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_row(m_row), .m_col(m_col), .m_last_col(m_last_col), .m_last(m_last),
    .frame_cnt(frame_cnt)
  );

  conv_out_streamer #(
    .OUTROW(R), .OUTCOL(C), .IN_WIDTH(20), .TX_WIDTH(8), .CNT_WIDTH(2)
  ) dut_wrap (
    .clk(clk), .rst(rst), .frame_valid(frame_valid), .frame_ready(frame_ready2),
    .conv_out(conv_out), .m_valid(m_valid2), .m_ready(m_ready), .m_data(m_data2),
    .m_row(m_row2), .m_col(m_col2), .m_last_col(m_last_col2), .m_last(m_last2),
    .frame_cnt(frame_cnt2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cycle++;
  endtask

  task automatic set_ramp();
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) begin
        conv_out[r][c]   = 20'(5 * r + c);
        exp_pix[5*r + c] = 8'(5 * r + c);
      end
  endtask

  task automatic set_clamp();
    logic [19:0] cv [0:4];
    logic [7:0]  ce [0:4];
    cv = '{20'hFFFFD, 20'h00000, 20'h000FF, 20'h00100, 20'h7FFFF};
    ce = '{8'd0, 8'd0, 8'd255, 8'd255, 8'd255};
    for (int k = 0; k < N; k++) begin
      conv_out[k/C][k%C] = cv[k%5];
      exp_pix[k]         = ce[k%5];
    end
  endtask

  task automatic set_tens();
    for (int k = 0; k < N; k++) begin
      conv_out[k/C][k%C] = 20'(10 * k);
      exp_pix[k]         = 8'(10 * k);
    end
  endtask

  // Present a frame and wait for it to be captured.
  task automatic capture(output int cap_cycle);
    frame_valid = 1'b1;
    for (int i = 0; i < 100 && !frame_ready; i++) tick();
    chk("ready_before_capture", 32'(frame_ready), 32'd1);
    tick();
    frame_valid = 1'b0;
    cap_cycle = cycle;
    chk("load_m_valid", 32'(m_valid), 32'd0);
    chk("load_frame_ready", 32'(frame_ready), 32'd0);
  endtask

  function automatic logic [31:0] payload();
    return 32'({m_data, m_row, m_col, m_last_col, m_last});
  endfunction

  // Receive nbeats beats and check each against exp_pix and its coordinates.
  task automatic recv(input int nbeats, input bit rnd, input bit pulse, input int cap_cycle);
    int k = 0;
    int first = -1;
    int last = -1;
    logic held = 1'b0;
    logic [31:0] hp = '0;
    for (int t = 0; t < 2000 && k < nbeats; t++) begin
      m_ready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (pulse && t == 8) begin
        frame_valid = 1'b1;
        for (int i = 0; i < N; i++) conv_out[i/C][i%C] = 20'd77;
      end
      if (pulse && t == 9) frame_valid = 1'b0;
      if (held) begin
        chk("hold_valid", 32'(m_valid), 32'd1);
        chk("hold_payload", payload(), hp);
      end
      held = 1'b0;
      if (m_valid) begin
        if (first < 0) first = cycle;
        if (m_ready) begin
          chk("beat_data", 32'(m_data), 32'(exp_pix[k]));
          chk("beat_row", 32'(m_row), 32'(k / C));
          chk("beat_col", 32'(m_col), 32'(k % C));
          chk("beat_last_col", 32'(m_last_col), 32'((k % C) == C - 1));
          chk("beat_last", 32'(m_last), 32'(k == N - 1));
          last = cycle;
          k++;
        end else begin
          held = 1'b1;
          hp   = payload();
        end
      end
      tick();
    end
    chk("beat_count", 32'(k), 32'(nbeats));
    chk("first_beat_latency", 32'(first - cap_cycle), 32'd1);
    if (!rnd) chk("no_bubble", 32'(last - first), 32'(nbeats - 1));
    if (nbeats == N) begin
      chk("end_m_valid", 32'(m_valid), 32'd0);
      chk("end_frame_ready", 32'(frame_ready), 32'd1);
    end
  endtask

  // frame_valid held high for nframes ramp frames with m_ready=1.
  task automatic b2b(input int nframes);
    int k = 0;
    int zeros = 0;
    int start;
    set_ramp();
    m_ready = 1'b1;
    frame_valid = 1'b1;
    start = cycle;
    for (int t = 0; t < nframes * 27 + 20 && k < nframes * N; t++) begin
      if (m_valid) begin
        chk("b2b_data", 32'(m_data), 32'(exp_pix[k % N]));
        chk("b2b_row", 32'(m_row), 32'((k % N) / C));
        chk("b2b_col", 32'(m_col), 32'(k % C));
        chk("b2b_last", 32'(m_last), 32'((k % N) == N - 1));
        k++;
      end else begin
        zeros++;
      end
      tick();
    end
    frame_valid = 1'b0;
    chk("b2b_beats", 32'(k), 32'(nframes * N));
    chk("b2b_cycles", 32'(cycle - start), 32'(nframes * 27));
    chk("b2b_gap_cycles", 32'(zeros), 32'(nframes * 2));
    tick();
    chk("b2b_idle_m_valid", 32'(m_valid), 32'd0);
  endtask

  initial begin
    int cc;
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) conv_out[r][c] = '0;

    // Reset held with frame_valid toggling.
    for (int i = 0; i < 4; i++) begin
      frame_valid = ~frame_valid;
      tick();
    end
    frame_valid = 1'b0;
    chk("rst_frame_ready", 32'(frame_ready), 32'd1);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("rst_payload", payload(), 32'd0);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    chk("idle_frame_ready", 32'(frame_ready), 32'd1);
    chk("idle_m_valid", 32'(m_valid), 32'd0);
    chk("idle_frame_cnt", 32'(frame_cnt), 32'd0);

    // Ramp frame.
    set_ramp();
    capture(cc);
    recv(N, 1'b0, 1'b0, cc);
    chk("ramp_frame_cnt", 32'(frame_cnt), 32'd1);

    // Clamp frame.
    set_clamp();
    capture(cc);
    recv(N, 1'b0, 1'b0, cc);
    chk("clamp_frame_cnt", 32'(frame_cnt), 32'd2);

    // Backpressure with an ignored mid-frame frame_valid pulse.
    set_tens();
    capture(cc);
    recv(N, 1'b1, 1'b1, cc);
    chk("bp_frame_cnt", 32'(frame_cnt), 32'd3);
    tick();
    chk("bp_no_recapture", 32'(m_valid), 32'd0);

    // Reset after beat 12.
    set_ramp();
    capture(cc);
    recv(13, 1'b0, 1'b0, cc);
    chk("pre_rst_m_valid", 32'(m_valid), 32'd1);
    rst = 1'b0;
    #1;
    chk("midrst_m_valid", 32'(m_valid), 32'd0);
    chk("midrst_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("midrst_frame_ready", 32'(frame_ready), 32'd1);
    chk("midrst_wrap_cnt", 32'(frame_cnt2), 32'd0);
    tick();
    rst = 1'b1;
    tick();

    // Back-to-back frames, then counter wrap on the 2-bit instance.
    b2b(3);
    chk("b2b_frame_cnt", 32'(frame_cnt), 32'd3);
    chk("b2b_wrap_cnt3", 32'(frame_cnt2), 32'd3);
    b2b(2);
    chk("b2b_frame_cnt5", 32'(frame_cnt), 32'd5);
    chk("wrap_frame_cnt", 32'(frame_cnt2), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
